mcs51_xbus_master: RTL
======================

Name: mcs51_xbus_master

Overview:
- Drives the MCS-51 multiplexed external bus: P0 address/data, P2 high address, ALE, PSEN_n, RD_n, WR_n.
- It is the transmitting end of the external address-latch interface. The low address on P0 is framed with ALE so that a transparent latch, enabled while ALE is high, holds A[7:0] after ALE falls.
- Sits between the core's fetch/MOVX sequencer and the port pads.
- One transaction at a time; a req/ack handshake to the core.

Parameters:
- ALE_CYCLES, 1, number of clocks ALE is high with the address driven on P0 (1..4).
- STROBE_CYCLES, 2, number of clocks PSEN_n/RD_n/WR_n is low (1..8).

Ports:
- clk  in  1  single system clock, all state changes on rising edge
- rst  in  1  synchronous reset, active-high
- req  in  1  transaction request, sampled only in IDLE
- kind  in  2  00 code fetch (PSEN_n), 01 xdata read (RD_n), 10 xdata write (WR_n), 11 no-op
- short_addr  in  1  1 = MOVX @Ri: P2 carries p2_sfr instead of addr[15:8]
- addr  in  16  transaction address
- wdata  in  8  write data
- p2_sfr  in  8  current P2 SFR value
- ack  out  1  one-cycle pulse, transaction complete
- rdata  out  8  read/fetch data, valid from the ack cycle until the next ack
- ale  out  1  address latch enable, active-high
- psen_n  out  1  program store enable, active-low
- rd_n  out  1  external read strobe, active-low
- wr_n  out  1  external write strobe, active-low
- p0_out  out  8  P0 drive value
- p0_oe  out  1  P0 output enable, 1 = drive
- p0_in  in  8  P0 pad input
- p2_out  out  8  P2 drive value

Behaviour:
- All outputs are registered.
- Reset values: ale=0, psen_n=rd_n=wr_n=1, p0_oe=0, p0_out=8'h00, p2_out=8'hFF, ack=0, rdata=8'h00, state=IDLE.
- Reset mid-transaction:
  - All strobes deassert and ALE drops at that edge.
  - No ack is issued.
  - The command is discarded.

State machine: IDLE -> ADDR -> HOLD -> STROBE -> END -> IDLE.

IDLE:
- Strobes high, ale=0, p0_oe=0, p2_out<=p2_sfr.
- When req=1 at a rising edge, capture kind, short_addr, addr and wdata into command registers.
- Inputs are ignored after capture.
- kind=11: go to END with ack=1 next cycle, rdata unchanged, no pin activity.

ADDR (ALE_CYCLES clocks):
- ale=1, p0_oe=1, p0_out=addr[7:0].
- p2_out = short_addr ? p2_sfr(captured) : addr[15:8].

HOLD (1 clock):
- ale=0.
- P0 still drives addr[7:0] (latch hold time).
- P2 unchanged.

STROBE (STROBE_CYCLES clocks):
- Fetch: psen_n=0, p0_oe=0.
- Read: rd_n=0, p0_oe=0.
- Write: wr_n=0, p0_oe=1, p0_out=wdata.
- Only one strobe is ever low.
- Strobes never overlap ale=1.

END (1 clock):
- Strobes high, ack=1.
- For fetch and read, rdata <= p0_in as sampled at the edge that leaves STROBE. This is the last strobe-low cycle's data.
- For write, P0 keeps driving wdata (data hold); p0_oe drops on exit.
- P2 keeps its address during END.

Timing and handshake:
- Latency from the accepting edge to ack-high: ALE_CYCLES+STROBE_CYCLES+2 clocks (defaults: 5).
- A req held high through END is not accepted until the IDLE cycle that follows.
- So back-to-back transactions have at least one IDLE cycle between them, with ale=0 and p0_oe=0.
- Parameter values outside their ranges are unsupported. The implementation must assert on them in simulation.

Test Plan:
1. Reset, then fetch: kind=00, addr=16'h1234, p0_in=8'hA5 during strobe.
   - ale high exactly 1 cycle with p0_out=34, p2_out=12.
   - psen_n low 2 cycles, rd_n and wr_n stay 1.
   - ack 5 cycles after accept, rdata=A5.
2. Write: kind=10, addr=16'hBEEF, wdata=8'h5A.
   - P0 drives EF through ADDR and HOLD, then 5A.
   - wr_n low 2 cycles, P0=5A still driven in the END cycle.
   - p2_out=BE, rdata unchanged.
3. Short MOVX read: short_addr=1, addr=16'h0077, p2_sfr=8'h80.
   - p2_out=80 through the transaction, p0 address=77.
   - rd_n low, ack, rdata=p0_in.
   - p2_out then follows p2_sfr in IDLE.
4. Back-to-back: req held high over two reads.
   - Second ale rises only after one IDLE cycle.
   - Exactly two ack pulses, in cycles 5 and 11.
5. Reset asserted during STROBE of a write.
   - wr_n=1, p0_oe=0, ale=0 the next cycle.
   - No ack; p2_out=FF.
6. kind=11.
   - ack one cycle after accept.
   - ale, psen_n, rd_n, wr_n, p0_oe never change.
   - Repeat 1 with ALE_CYCLES=2, STROBE_CYCLES=3: ack latency 7.

Source files
------------

// File: rtl/mcs51_xbus_master_if.sv
// MCS-51 external bus bundle: core-side req/ack command port plus the P0/P2/strobe pad signals.
// master = the bus sequencer, slave = the core and pads driving it.
interface mcs51_xbus_master_if;
    logic        req;
    logic [1:0]  kind;
    logic        short_addr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  p2_sfr;
    logic        ack;
    logic [7:0]  rdata;
    logic        ale;
    logic        psen_n;
    logic        rd_n;
    logic        wr_n;
    logic [7:0]  p0_out;
    logic        p0_oe;
    logic [7:0]  p0_in;
    logic [7:0]  p2_out;

    modport master (
        input  req, kind, short_addr, addr, wdata, p2_sfr, p0_in,
        output ack, rdata, ale, psen_n, rd_n, wr_n, p0_out, p0_oe, p2_out
    );

    modport slave (
        output req, kind, short_addr, addr, wdata, p2_sfr, p0_in,
        input  ack, rdata, ale, psen_n, rd_n, wr_n, p0_out, p0_oe, p2_out
    );
endinterface

// File: rtl/mcs51_xbus_master.sv
// MCS-51 multiplexed external bus master: ALE-framed address on P0/P2, then one PSEN_n/RD_n/WR_n strobe.
// Ack ALE_CYCLES+STROBE_CYCLES+2 cycles after accept (1 for no-op); one transaction at a time, req sampled only in IDLE.
module mcs51_xbus_master #(
    parameter int ALE_CYCLES    = 1,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mcs51_xbus_master_if.master  bus
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_HOLD, S_STROBE, S_END} state_t;

    localparam logic [1:0] K_FETCH = 2'b00;
    localparam logic [1:0] K_READ  = 2'b01;
    localparam logic [1:0] K_WRITE = 2'b10;
    localparam logic [1:0] K_NOP   = 2'b11;
    localparam logic [3:0] ALE_LAST = 4'(ALE_CYCLES - 1);
    localparam logic [3:0] STB_LAST = 4'(STROBE_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [1:0]  cmd_kind;
    logic        cmd_short;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic [7:0]  cmd_p2;

    logic [1:0]  e_kind;
    logic        e_short;
    logic [15:0] e_addr;
    logic [7:0]  e_wdata;
    logic [7:0]  e_p2;

    logic        ale_r, psen_n_r, rd_n_r, wr_n_r, p0_oe_r, ack_r;
    logic [7:0]  p0_out_r, p2_out_r, rdata_r;
    logic        ale_nxt, psen_n_nxt, rd_n_nxt, wr_n_nxt, p0_oe_nxt, ack_nxt;
    logic [7:0]  p0_out_nxt, p2_out_nxt, rdata_nxt;

    // Pins are registered from the next state, so on the accepting edge the
    // command comes straight from the inputs rather than the command registers.
    always_comb begin
        e_kind  = cmd_kind;
        e_short = cmd_short;
        e_addr  = cmd_addr;
        e_wdata = cmd_wdata;
        e_p2    = cmd_p2;
        if (state == S_IDLE) begin
            e_kind  = bus.kind;
            e_short = bus.short_addr;
            e_addr  = bus.addr;
            e_wdata = bus.wdata;
            e_p2    = bus.p2_sfr;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        ale_nxt    = 1'b0;
        psen_n_nxt = 1'b1;
        rd_n_nxt   = 1'b1;
        wr_n_nxt   = 1'b1;
        p0_oe_nxt  = 1'b0;
        ack_nxt    = 1'b0;
        p0_out_nxt = p0_out_r;
        p2_out_nxt = p2_out_r;
        rdata_nxt  = rdata_r;

        case (state)
            S_IDLE: begin
                if (bus.req) begin
                    state_nxt = (bus.kind == K_NOP) ? S_END : S_ADDR;
                    cnt_nxt   = '0;
                end
            end
            S_ADDR: begin
                if (cnt == ALE_LAST) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_HOLD: begin
                state_nxt = S_STROBE;
                cnt_nxt   = '0;
            end
            S_STROBE: begin
                if (cnt == STB_LAST) state_nxt = S_END;
                else                 cnt_nxt   = cnt + 4'd1;
            end
            S_END:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        case (state_nxt)
            S_IDLE: p2_out_nxt = bus.p2_sfr;
            S_ADDR: begin
                ale_nxt    = 1'b1;
                p0_oe_nxt  = 1'b1;
                p0_out_nxt = e_addr[7:0];
                p2_out_nxt = e_short ? e_p2 : e_addr[15:8];
            end
            S_HOLD: begin
                p0_oe_nxt  = 1'b1;
                p0_out_nxt = e_addr[7:0];
            end
            S_STROBE: begin
                case (e_kind)
                    K_FETCH: psen_n_nxt = 1'b0;
                    K_READ:  rd_n_nxt   = 1'b0;
                    K_WRITE: begin
                        wr_n_nxt   = 1'b0;
                        p0_oe_nxt  = 1'b1;
                        p0_out_nxt = e_wdata;
                    end
                    default: ;
                endcase
            end
            S_END: begin
                ack_nxt = 1'b1;
                if (e_kind == K_WRITE) begin
                    p0_oe_nxt  = 1'b1;
                    p0_out_nxt = e_wdata;
                end
                // Sampled on the edge leaving STROBE: the last strobe-low cycle's data.
                if (state == S_STROBE && (e_kind == K_FETCH || e_kind == K_READ))
                    rdata_nxt = bus.p0_in;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cmd_kind  <= K_NOP;
            cmd_short <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_p2    <= '0;
            ale_r     <= 1'b0;
            psen_n_r  <= 1'b1;
            rd_n_r    <= 1'b1;
            wr_n_r    <= 1'b1;
            p0_oe_r   <= 1'b0;
            p0_out_r  <= 8'h00;
            p2_out_r  <= 8'hFF;
            ack_r     <= 1'b0;
            rdata_r   <= 8'h00;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ale_r    <= ale_nxt;
            psen_n_r <= psen_n_nxt;
            rd_n_r   <= rd_n_nxt;
            wr_n_r   <= wr_n_nxt;
            p0_oe_r  <= p0_oe_nxt;
            p0_out_r <= p0_out_nxt;
            p2_out_r <= p2_out_nxt;
            ack_r    <= ack_nxt;
            rdata_r  <= rdata_nxt;
            if (state == S_IDLE && bus.req) begin
                cmd_kind  <= bus.kind;
                cmd_short <= bus.short_addr;
                cmd_addr  <= bus.addr;
                cmd_wdata <= bus.wdata;
                cmd_p2    <= bus.p2_sfr;
            end
        end
    end

    assign bus.ale    = ale_r;
    assign bus.psen_n = psen_n_r;
    assign bus.rd_n   = rd_n_r;
    assign bus.wr_n   = wr_n_r;
    assign bus.p0_oe  = p0_oe_r;
    assign bus.p0_out = p0_out_r;
    assign bus.p2_out = p2_out_r;
    assign bus.ack    = ack_r;
    assign bus.rdata  = rdata_r;

    always @(posedge clk) begin
        assert (ALE_CYCLES >= 1 && ALE_CYCLES <= 4)
            else $error("ALE_CYCLES out of range 1..4");
        assert (STROBE_CYCLES >= 1 && STROBE_CYCLES <= 8)
            else $error("STROBE_CYCLES out of range 1..8");
        if (!rst) begin
            assert ({psen_n_r, rd_n_r, wr_n_r} inside {3'b111, 3'b011, 3'b101, 3'b110})
                else $error("more than one strobe low");
            assert (!(ale_r && !(psen_n_r && rd_n_r && wr_n_r)))
                else $error("strobe overlaps ale");
        end
    end
endmodule
